// File: rtl/cache_controller_if.sv
// Bus bundle for cache_controller: the CPU request/response signals, the
// backing-memory handshake and the state_mode status output.
// The controller connects through the slave modport. A CPU plus memory
// environment connects through the master modport.
interface cache_controller_if;
    logic [31:0]  cpu_req_addr;
    logic [127:0] cpu_req_datain;
    logic [31:0]  cpu_req_dataout;
    logic         cpu_req_rw;
    logic         cpu_req_valid;
    logic         cache_ready;

    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_dataout;
    logic [127:0] mem_req_datain;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic         mem_req_ready;

    logic [31:0]  state_mode;

    modport slave (
        input  cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
        input  mem_req_datain, mem_req_ready,
        output cpu_req_dataout, cache_ready,
        output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
        output state_mode
    );

    modport master (
        output cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
        output mem_req_datain, mem_req_ready,
        input  cpu_req_dataout, cache_ready,
        input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
        input  state_mode
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller.
// The cache has 1024 lines of 128 bits each. The address fields are
// tag [31:14], index [13:4] and offset [3:0].
// The flow is IDLE -> COMPARE -> IDLE / WRITEBACK / ALLOCATE.
// A write miss does not fetch the block, because the CPU always supplies
// the whole 128-bit block.
// Optional feature: define CACHE_STATS_EN to add the hit_count and
// miss_count outputs. Each counter is 32 bits wide.
module cache_controller (
    input  logic              clk,
    input  logic              rst,
    cache_controller_if.slave io_bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    localparam logic [31:0] MODE_NONE       = 32'd0;
    localparam logic [31:0] MODE_HIT        = 32'd1;
    localparam logic [31:0] MODE_CLEAN_MISS = 32'd2;
    localparam logic [31:0] MODE_DIRTY_MISS = 32'd3;

    // Controller state and registered outputs
    state_t         r_state;
    logic           r_ready;
    logic           r_mem_valid;
    logic           r_mem_rw;
    logic [31:0]    r_mem_addr;
    logic [127:0]   r_mem_dataout;
    logic [31:0]    r_cpu_dataout;
    logic [31:0]    r_state_mode;

    // Request captured at acceptance; every later stage works only from this copy
    logic [31:0]    r_addr;
    logic [127:0]   r_wdata;
    logic           r_rw;

    // Line status bits, cleared by reset
    logic [1023:0]  r_valid;
    logic [1023:0]  r_dirty;

    // Line contents, never reset; they are meaningful only while the valid bit is set
    logic [17:0]    r_tag_mem  [0:1023];
    logic [127:0]   r_data_mem [0:1023];

    logic [17:0]    w_tag;
    logic [9:0]     w_index;
    logic [1:0]     w_word;
    logic [17:0]    w_line_tag;
    logic [127:0]   w_line_data;
    logic           w_hit;
    logic           w_victim_dirty;
    logic           w_mem_done;
    logic           w_accept;
    logic           w_line_we;
    logic [127:0]   w_line_wdata;
    logic           w_unused_ok;

    function automatic logic [31:0] f_select_word(input logic [127:0] blk,
                                                  input logic [1:0]   sel);
        logic [31:0] word;
        word = blk[31:0];
        case (sel)
            2'd0: word = blk[31:0];
            2'd1: word = blk[63:32];
            2'd2: word = blk[95:64];
            2'd3: word = blk[127:96];
            default: word = blk[31:0];
        endcase
        return word;
    endfunction

    assign w_tag          = r_addr[31:14];
    assign w_index        = r_addr[13:4];
    assign w_word         = r_addr[3:2];
    assign w_line_tag     = r_tag_mem[w_index];
    assign w_line_data    = r_data_mem[w_index];
    assign w_hit          = r_valid[w_index] && (w_line_tag == w_tag);
    assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
    // A memory beat completes only while this side is actually requesting
    assign w_mem_done     = r_mem_valid && io_bus.mem_req_ready;
    // cache_ready is high only in IDLE, so it alone qualifies acceptance
    assign w_accept       = r_ready && io_bus.cpu_req_valid;
    // Byte-within-word address bits do not select anything
    assign w_unused_ok    = &{1'b0, r_addr[1:0]};

    // Decide when the addressed line's tag/data get rewritten: write hit, write miss
    // completion (direct or after writeback) and allocate fill
    always_comb begin
        w_line_we    = 1'b0;
        w_line_wdata = r_wdata;
        if (!rst) begin
            case (r_state)
                S_COMPARE:   w_line_we = r_rw && (w_hit || !w_victim_dirty);
                S_WRITEBACK: w_line_we = w_mem_done && r_rw;
                S_ALLOCATE: begin
                    w_line_we    = w_mem_done;
                    w_line_wdata = io_bus.mem_req_datain;
                end
                default:     w_line_we = 1'b0;
            endcase
        end
    end

    // Line storage: tag and data are always written together
    always_ff @(posedge clk) begin
        if (w_line_we) begin
            r_tag_mem[w_index]  <= w_tag;
            r_data_mem[w_index] <= w_line_wdata;
        end
    end

    // Main FSM: request capture, lookup, writeback/allocate handshakes, status bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_ready       <= 1'b1;
            r_mem_valid   <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_dataout <= '0;
            r_cpu_dataout <= '0;
            r_state_mode  <= MODE_NONE;
        end else begin
            // Outcome codes are reported only for the cycle after a lookup
            r_state_mode <= MODE_NONE;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= io_bus.cpu_req_addr;
                        r_wdata <= io_bus.cpu_req_datain;
                        r_rw    <= io_bus.cpu_req_rw;
                        r_ready <= 1'b0;
                        r_state <= S_COMPARE;
                    end
                end

                S_COMPARE: begin
                    if (w_hit) begin
                        r_state_mode <= MODE_HIT;
                        if (r_rw) begin
                            r_dirty[w_index] <= 1'b1;
                        end else begin
                            r_cpu_dataout <= f_select_word(w_line_data, w_word);
                        end
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_victim_dirty) begin
                        r_state_mode  <= MODE_DIRTY_MISS;
                        r_mem_valid   <= 1'b1;
                        r_mem_rw      <= 1'b1;
                        r_mem_addr    <= {w_line_tag, w_index, 4'b0000};
                        r_mem_dataout <= w_line_data;
                        r_state       <= S_WRITEBACK;
                    end else begin
                        r_state_mode <= MODE_CLEAN_MISS;
                        if (r_rw) begin
                            // Write-allocate without a fetch: the CPU supplies the full block
                            r_valid[w_index] <= 1'b1;
                            r_dirty[w_index] <= 1'b1;
                            r_ready          <= 1'b1;
                            r_state          <= S_IDLE;
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_mem_rw    <= 1'b0;
                            r_mem_addr  <= {w_tag, w_index, 4'b0000};
                            r_state     <= S_ALLOCATE;
                        end
                    end
                end

                S_WRITEBACK: begin
                    if (w_mem_done) begin
                        r_mem_valid <= 1'b0;
                        if (r_rw) begin
                            r_valid[w_index] <= 1'b1;
                            r_dirty[w_index] <= 1'b1;
                            r_ready          <= 1'b1;
                            r_state          <= S_IDLE;
                        end else begin
                            r_dirty[w_index] <= 1'b0;
                            r_state          <= S_ALLOCATE;
                        end
                    end
                end

                S_ALLOCATE: begin
                    if (w_mem_done) begin
                        r_mem_valid      <= 1'b0;
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_COMPARE;
                    end else if (!r_mem_valid) begin
                        // Coming from a writeback: valid dropped for one cycle, now issue the fetch
                        r_mem_valid <= 1'b1;
                        r_mem_rw    <= 1'b0;
                        r_mem_addr  <= {w_tag, w_index, 4'b0000};
                    end
                end

                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_first_lookup;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit/miss statistics: only the first lookup of each request counts, not the
    // re-compare that follows an allocate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_lookup <= 1'b0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_first_lookup <= 1'b1;
            end else if (r_state == S_COMPARE) begin
                r_first_lookup <= 1'b0;
                if (r_first_lookup) begin
                    if (w_hit) begin
                        r_hit_count <= r_hit_count + 32'd1;
                    end else begin
                        r_miss_count <= r_miss_count + 32'd1;
                    end
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    assign io_bus.cache_ready     = r_ready;
    assign io_bus.mem_req_valid   = r_mem_valid;
    assign io_bus.mem_req_rw      = r_mem_rw;
    assign io_bus.mem_req_addr    = r_mem_addr;
    assign io_bus.mem_req_dataout = r_mem_dataout;
    assign io_bus.cpu_req_dataout = r_cpu_dataout;
    assign io_bus.state_mode      = r_state_mode;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller. It runs directed scenarios first and then
// random traffic. Results are compared with a line-level cache model and a
// separate backing memory model.
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_controller_if bus();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct packed {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } txn_t;

    int   checks   = 0;
    int   failures = 0;
    txn_t log_q[$];
    txn_t exp_q[$];

    // Environment memory, written only by the responder
    logic [127:0] env_mem [logic [31:0]];
    // Reference model state
    logic [127:0] ref_mem [logic [31:0]];
    bit           m_valid [1024];
    bit           m_dirty [1024];
    logic [17:0]  m_tag   [1024];
    logic [127:0] m_data  [1024];
    logic [31:0]  exp_dout;
    int           exp_hits;
    int           exp_misses;

    int mem_lat  = 0;
    bit lat_rand = 1'b0;

    function automatic logic [127:0] mem_init(input logic [31:0] a);
        return {a ^ 32'hC0DE_0003, a + 32'h1111_0002, ~a, a ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [127:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_dout   = 32'd0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    // Line-level behaviour: hit, dirty victim writeback, fetch on read miss,
    // and a fetch-free fill on write miss
    task automatic model_access(input logic [31:0] addr, input bit rw,
                                input logic [127:0] data, output int mode);
        int           idx;
        int           w;
        logic [17:0]  tg;
        logic [31:0]  victim;
        logic [31:0]  blk;
        logic [127:0] line;
        txn_t         t;
        idx = int'(addr[13:4]);
        w   = int'(addr[3:2]);
        tg  = addr[31:14];
        exp_q.delete();
        if (m_valid[idx] && m_tag[idx] == tg) begin
            mode = 1;
            exp_hits++;
            if (rw) begin
                m_data[idx]  = data;
                m_dirty[idx] = 1'b1;
            end else begin
                line     = m_data[idx];
                exp_dout = line[w*32 +: 32];
            end
        end else begin
            exp_misses++;
            mode = (m_valid[idx] && m_dirty[idx]) ? 3 : 2;
            if (mode == 3) begin
                victim          = {m_tag[idx], addr[13:4], 4'h0};
                ref_mem[victim] = m_data[idx];
                t.rw = 1'b1; t.addr = victim; t.data = m_data[idx];
                exp_q.push_back(t);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            if (rw) begin
                m_data[idx]  = data;
                m_dirty[idx] = 1'b1;
            end else begin
                blk  = {tg, addr[13:4], 4'h0};
                t.rw = 1'b0; t.addr = blk; t.data = '0;
                exp_q.push_back(t);
                line         = ref_rd(blk);
                m_data[idx]  = line;
                m_dirty[idx] = 1'b0;
                exp_dout     = line[w*32 +: 32];
            end
        end
    endtask

    // Backing memory: waits a programmable number of valid cycles, then pulses ready
    initial begin
        int cnt;
        int lat;
        bit busy;
        txn_t t;
        cnt  = 0;
        lat  = 0;
        busy = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_req_datain = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_req_ready = 1'b0;
                busy = 1'b0;
                cnt  = 0;
            end else if (bus.mem_req_ready) begin
                bus.mem_req_ready = 1'b0;
            end else if (bus.mem_req_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    lat  = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (cnt >= lat) begin
                    bus.mem_req_ready = 1'b1;
                    busy = 1'b0;
                    t.rw   = bus.mem_req_rw;
                    t.addr = bus.mem_req_addr;
                    if (bus.mem_req_rw) begin
                        env_mem[bus.mem_req_addr] = bus.mem_req_dataout;
                        t.data = bus.mem_req_dataout;
                    end else begin
                        bus.mem_req_datain = env_mem.exists(bus.mem_req_addr) ?
                                             env_mem[bus.mem_req_addr] : mem_init(bus.mem_req_addr);
                        t.data = '0;
                    end
                    log_q.push_back(t);
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cache_ready"}, 128'(bus.cache_ready), 128'(1));
        chk({tag, "_mem_valid"},   128'(bus.mem_req_valid), 128'(0));
        chk({tag, "_mem_rw"},      128'(bus.mem_req_rw), 128'(0));
        chk({tag, "_mem_addr"},    128'(bus.mem_req_addr), 128'(0));
        chk({tag, "_mem_dout"},    bus.mem_req_dataout, 128'(0));
        chk({tag, "_cpu_dout"},    128'(bus.cpu_req_dataout), 128'(0));
        chk({tag, "_state_mode"},  128'(bus.state_mode), 128'(0));
    endtask

    // One full CPU request checked against the model. It outputs the first
    // state_mode seen and the number of cycles with mem_req_valid high.
    task automatic do_req(input logic [31:0] addr, input bit rw, input logic [127:0] data,
                          output int got_mode, output int vcnt);
        int           exp_mode;
        int           n;
        bit           pv;
        logic [31:0]  pa;
        logic         pr;
        logic [127:0] pd;
        model_access(addr, rw, data, exp_mode);
        n = 0;
        while (bus.cache_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_req", 128'(bus.cache_ready), 128'(1));
        log_q.delete();
        bus.cpu_req_addr   = addr;
        bus.cpu_req_rw     = rw;
        bus.cpu_req_datain = data;
        bus.cpu_req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        got_mode = 0;
        vcnt     = 0;
        pv       = 1'b0;
        pa       = '0;
        pr       = 1'b0;
        pd       = '0;
        n        = 0;
        while (n < 300) begin
            if (got_mode == 0 && bus.state_mode != 0) got_mode = int'(bus.state_mode);
            if (bus.mem_req_valid) begin
                vcnt++;
                chk("ready_low_during_mem", 128'(bus.cache_ready), 128'(0));
                if (pv) begin
                    chk("mem_addr_stable", 128'(bus.mem_req_addr), 128'(pa));
                    chk("mem_rw_stable",   128'(bus.mem_req_rw), 128'(pr));
                    chk("mem_dout_stable", bus.mem_req_dataout, pd);
                end
                pv = 1'b1;
                pa = bus.mem_req_addr;
                pr = bus.mem_req_rw;
                pd = bus.mem_req_dataout;
            end else begin
                pv = 1'b0;
            end
            if (bus.cache_ready) break;
            // Junk requests while busy must be ignored
            bus.cpu_req_valid  = 1'($urandom_range(0, 1));
            bus.cpu_req_addr   = $urandom;
            bus.cpu_req_rw     = 1'($urandom_range(0, 1));
            bus.cpu_req_datain = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end
        bus.cpu_req_valid = 1'b0;
        chk("req_completes", 128'(n < 300), 128'(1));
        chk("state_mode", 128'(got_mode), 128'(exp_mode));
        chk("cpu_dataout", 128'(bus.cpu_req_dataout), 128'(exp_dout));
        chk("mem_txn_count", 128'(log_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk("mem_txn_rw",   128'(log_q[i].rw), 128'(exp_q[i].rw));
            chk("mem_txn_addr", 128'(log_q[i].addr), 128'(exp_q[i].addr));
            chk("mem_txn_data", log_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        int           mode;
        int           vc;
        int           n;
        logic [127:0] blk;
        logic [9:0]   idx_pool [4];
        logic [31:0]  a;

        rst                = 1'b1;
        bus.cpu_req_addr   = '0;
        bus.cpu_req_datain = '0;
        bus.cpu_req_rw     = 1'b0;
        bus.cpu_req_valid  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        // Write then read hit with no memory traffic
        do_req(32'h0000_6B00, 1'b1, 128'h0066_3322, mode, vc);
        do_req(32'h0000_6B00, 1'b0, 128'h0, mode, vc);
        chk("r025_mode", 128'(mode), 128'(1));
        chk("r025_dout", 128'(bus.cpu_req_dataout), 128'h0066_3322);
        chk("r025_no_mem", 128'(log_q.size()), 128'(0));

        // Same index with a dirty victim: writeback first, then fetch
        do_req(32'h0000_EB00, 1'b0, 128'h0, mode, vc);
        chk("r026_mode", 128'(mode), 128'(3));
        chk("r026_txns", 128'(log_q.size()), 128'(2));
        if (log_q.size() == 2) begin
            chk("r026_wb_addr", 128'(log_q[0].addr), 128'h6B00);
            chk("r026_wb_data", log_q[0].data, 128'h0066_3322);
            chk("r026_rd_addr", 128'(log_q[1].addr), 128'hEB00);
        end
        blk = mem_init(32'h0000_EB00);
        chk("r026_dout", 128'(bus.cpu_req_dataout), 128'(blk[31:0]));

        // Cold read followed by hit on word 1
        do_req(32'h0000_DB00, 1'b0, 128'h0, mode, vc);
        chk("r027_mode", 128'(mode), 128'(2));
        chk("r027_txns", 128'(log_q.size()), 128'(1));
        do_req(32'h0000_DB04, 1'b0, 128'h0, mode, vc);
        chk("r027_hit_mode", 128'(mode), 128'(1));
        blk = mem_init(32'h0000_DB00);
        chk("r027_word1", 128'(bus.cpu_req_dataout), 128'(blk[63:32]));

        // Memory holds ready low for 5 cycles during the allocate
        mem_lat = 5;
        do_req(32'h0000_1230, 1'b0, 128'h0, mode, vc);
        chk("r028_valid_cycles", 128'(vc), 128'(6));

        // Reset in the middle of a writeback
        mem_lat = 0;
        do_req(32'h0000_6B00, 1'b1, 128'h0000_00AA_0055_0000_0000_0000_0000_1111, mode, vc);
        mem_lat = 40;
        bus.cpu_req_addr  = 32'h0000_EB00;
        bus.cpu_req_rw    = 1'b0;
        bus.cpu_req_valid = 1'b1;
        @(posedge clk); #1;
        bus.cpu_req_valid = 1'b0;
        n = 0;
        while (!(bus.mem_req_valid && bus.mem_req_rw) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("r029_in_writeback", 128'(bus.mem_req_valid && bus.mem_req_rw), 128'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("r029");
        model_reset();
        mem_lat = 0;
        do_req(32'h0000_6B00, 1'b0, 128'h0, mode, vc);
        chk("r029_mode", 128'(mode), 128'(2));
        chk("r029_dout", 128'(bus.cpu_req_dataout), 128'h0066_3322);

        // Random traffic over a few conflicting indices and tags
        lat_rand = 1'b1;
        idx_pool[0] = 10'd688;
        idx_pool[1] = 10'd689;
        idx_pool[2] = 10'h1B0;
        idx_pool[3] = 10'd1023;
        for (int k = 0; k < 150; k++) begin
            a = {14'($urandom_range(0, 5)), 4'h0,
                 idx_pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'b00};
            do_req(a, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom, $urandom, $urandom}, mode, vc);
        end

`ifdef CACHE_STATS_EN
        chk("hit_count",  128'(hit_count),  128'(exp_hits));
        chk("miss_count", 128'(miss_count), 128'(exp_misses));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port cpu_req_addr, input, 32: byte address; tag=[31:14] (18b), index=[13:4] (10b), offset=[3:0].
REQ-004 SHALL have port cpu_req_datain, input, 128: full-block write data.
REQ-005 SHALL have port cpu_req_dataout, output, 32: read word, selected by offset[3:2] (word 0 = bits [31:0]).
REQ-006 SHALL have ports cpu_req_rw (input, 1; 1=write, 0=read) and cpu_req_valid (input, 1; request strobe).
REQ-007 SHALL have port cache_ready, output, 1: high only in IDLE; the request is accepted on a clk edge with cpu_req_valid=1 and cache_ready=1.
REQ-008 SHALL have ports mem_req_addr (output, 32; block address {tag,index,4'b0}), mem_req_dataout (output, 128), mem_req_datain (input, 128).
REQ-009 SHALL have ports mem_req_rw (output, 1; 1=write), mem_req_valid (output, 1) and mem_req_ready (input, 1).
REQ-010 SHALL have port state_mode, output, 32-bit int: 0 idle/busy, 1 hit, 2 clean miss, 3 dirty miss.

Function
REQ-011 SHALL be direct-mapped: 1024 lines, each holding valid, dirty, 18-bit tag and 128-bit data.
REQ-012 SHALL use FSM IDLE->COMPARE->(IDLE | WRITEBACK | ALLOCATE); the accepted request is registered, so COMPARE occurs the cycle after acceptance.
REQ-013 SHALL in COMPARE detect a hit (valid and tag equal) and set state_mode=1; for a read hit, load cpu_req_dataout at that edge and return to IDLE; cpu_req_dataout holds until the next read hit.
REQ-014 SHALL on a write hit store cpu_req_datain into the line, set dirty=1, and return to IDLE.
REQ-015 SHALL on a miss with victim valid&dirty set state_mode=3 and enter WRITEBACK; otherwise set state_mode=2 and enter ALLOCATE (read) or perform the write directly (write).
REQ-016 SHALL in WRITEBACK drive mem_req_valid=1, mem_req_rw=1, mem_req_addr={victim tag,index,4'b0}, mem_req_dataout=victim data; when mem_req_ready=1 at an edge, clear dirty and go to ALLOCATE (read) or complete the write.
REQ-017 SHALL in ALLOCATE drive mem_req_valid=1, mem_req_rw=0, mem_req_addr={new tag,index,4'b0}; when mem_req_ready=1 at an edge, capture mem_req_datain, set valid=1, dirty=0, new tag, and return to COMPARE, which then hits.
REQ-018 SHALL complete a write miss as write-allocate without a fetch: the line gets the new tag and data with valid=1, dirty=1.
REQ-019 SHALL hold mem_req_valid asserted with stable addr, rw and data until mem_req_ready is sampled high; it deasserts the following cycle.
REQ-020 SHALL ignore cpu_req_valid while cache_ready=0.

Reset
REQ-021 SHALL on rst=1 at an edge enter IDLE and clear all valid and dirty bits, including mid-transaction; in-flight memory requests are abandoned.
REQ-022 SHALL reset outputs to: cache_ready=1, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_dataout=0, cpu_req_dataout=0, state_mode=0.

Configuration
REQ-023 SHALL, with CACHE_STATS_EN defined, add 32-bit outputs hit_count and miss_count, reset to 0 and incremented once per first COMPARE of a request (hit or miss), wrapping at 2^32.
REQ-024 SHALL, without CACHE_STATS_EN, omit these ports and counters entirely.

Verification
REQ-025 SHALL verify: after reset, write 0x6B00 with 0x663322, then read 0x6B00 -> state_mode=1, cpu_req_dataout=0x00663322, no memory request.
REQ-026 SHALL verify: read 0xEB00 (same index 688, dirty victim) -> state_mode=3; writeback to mem addr 0x6B00 with data 0x663322; read from 0xEB00; dataout=mem[0xEB00] word 0.
REQ-027 SHALL verify: read cold address 0xDB00 -> state_mode=2, single read at 0xDB00; then read 0xDB04 -> hit with word 1 (bits [63:32]).
REQ-028 SHALL verify: mem_req_ready held low for 5 cycles during ALLOCATE -> mem_req_valid and mem_req_addr stay stable; cache_ready=0 throughout.
REQ-029 SHALL verify: rst asserted during WRITEBACK -> next cycle IDLE, mem_req_valid=0; a subsequent read of 0x6B00 misses with state_mode=2.
